// File: rtl/vend_if.sv
// rtl/vend_if.sv - request/grant and dispenser signal bundle for the vend scheduler
interface vend_if #(
    parameter int N      = 4,
    parameter int CRED_W = 4
);
    logic [N-1:0]        req;
    logic [N*CRED_W-1:0] credit;
    logic [N-1:0]        gnt;
    logic [N-1:0]        done;
    logic [N-1:0]        rej;
    logic [N-1:0]        err;
    logic                disp_valid;
    logic                disp_ready;
    logic                disp_change;
    logic [CRED_W-1:0]   disp_chg_amt;
    logic                disp_done;
    logic                busy;
    logic                fault;
    logic                fault_clr;

    modport slave (
        input  req, credit, disp_ready, disp_done, fault_clr,
        output gnt, done, rej, err, disp_valid, disp_change, disp_chg_amt, busy, fault
    );

    modport master (
        output req, credit, disp_ready, disp_done, fault_clr,
        input  gnt, done, rej, err, disp_valid, disp_change, disp_chg_amt, busy, fault
    );
endinterface

// File: rtl/vend_scheduler.sv
// rtl/vend_scheduler.sv - round-robin arbiter sharing one dispenser among N coin front-ends
module vend_scheduler #(
    parameter int N       = 4,
    parameter int CRED_W  = 4,
    parameter int PRICE   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    vend_if.slave bus
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_WAIT_DONE, S_RESP, S_FAULT
    } state_t;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_ptr, w_ptr;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [CRED_W-1:0]  r_cred, w_cred;
    logic [TMR_W-1:0]   r_timer, w_timer;
    logic               r_ok, w_ok;
    logic [N-1:0]       r_gnt, w_gnt;
    logic [N-1:0]       r_done, w_done;
    logic [N-1:0]       r_rej, w_rej;
    logic [N-1:0]       r_err, w_err;
    logic               r_valid, w_valid;
    logic               r_chg, w_chg;
    logic [CRED_W-1:0]  r_amt, w_amt;
    logic               r_busy, w_busy;
    logic               r_fault, w_fault;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W-1:0]   w_cand;
    logic [CRED_W-1:0]  w_pick_cred;

    // Pointer increment modulo N (N need not be a power of two).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (v == IDX_W'(N - 1)) return '0;
        return v + 1'b1;
    endfunction

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
            w_cand = wrap_inc(w_cand);
        end
        w_pick_cred = bus.credit[int'(w_pick)*CRED_W +: CRED_W];
    end

    // Next-state and next-output logic; pulse outputs default low every cycle.
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_idx   = r_idx;
        w_cred  = r_cred;
        w_timer = r_timer;
        w_ok    = r_ok;
        w_gnt   = r_gnt;
        w_done  = '0;
        w_rej   = '0;
        w_err   = '0;
        w_valid = r_valid;
        w_chg   = r_chg;
        w_amt   = r_amt;
        w_fault = r_fault;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_idx   = w_pick;
                    w_cred  = w_pick_cred;
                    w_gnt   = N'(1) << w_pick;
                    w_ptr   = wrap_inc(w_pick);
                    w_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_cred < CRED_W'(PRICE)) begin
                    w_ok    = 1'b0;
                    w_state = S_RESP;
                end else begin
                    w_valid = 1'b1;
                    w_chg   = (r_cred > CRED_W'(PRICE));
                    w_amt   = r_cred - CRED_W'(PRICE);
                    w_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.disp_ready) begin
                    w_valid = 1'b0;
                    w_timer = '0;
                    w_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                // A completion on the last allowed cycle still counts as success.
                if (bus.disp_done) begin
                    w_ok    = 1'b1;
                    w_state = S_RESP;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_err   = N'(1) << r_idx;
                    w_gnt   = '0;
                    w_fault = 1'b1;
                    w_state = S_FAULT;
                end else begin
                    w_timer = r_timer + 1'b1;
                end
            end
            S_RESP: begin
                if (r_ok) w_done = N'(1) << r_idx;
                else      w_rej  = N'(1) << r_idx;
                w_gnt   = '0;
                w_chg   = 1'b0;
                w_amt   = '0;
                w_state = S_IDLE;
            end
            S_FAULT: begin
                if (bus.fault_clr) begin
                    w_fault = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
        w_busy = (w_state != S_IDLE);
    end

    // State and registered-output update; reset abandons any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_cred  <= '0;
            r_timer <= '0;
            r_ok    <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rej   <= '0;
            r_err   <= '0;
            r_valid <= 1'b0;
            r_chg   <= 1'b0;
            r_amt   <= '0;
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_idx   <= w_idx;
            r_cred  <= w_cred;
            r_timer <= w_timer;
            r_ok    <= w_ok;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_rej   <= w_rej;
            r_err   <= w_err;
            r_valid <= w_valid;
            r_chg   <= w_chg;
            r_amt   <= w_amt;
            r_busy  <= w_busy;
            r_fault <= w_fault;
        end
    end

    assign bus.gnt          = r_gnt;
    assign bus.done         = r_done;
    assign bus.rej          = r_rej;
    assign bus.err          = r_err;
    assign bus.disp_valid   = r_valid;
    assign bus.disp_change  = r_chg;
    assign bus.disp_chg_amt = r_amt;
    assign bus.busy         = r_busy;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_vend_scheduler.sv
// tb/tb_vend_scheduler.sv - randomized self-checking bench for vend_scheduler
module tb_vend_scheduler;
    localparam int N     = 4;
    localparam int CW    = 4;
    localparam int PRICE = 2;
    localparam int TO    = 16;
    localparam int W     = 4*N + CW + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vend_if #(.N(N), .CRED_W(CW)) bus();

    vend_scheduler #(.N(N), .CRED_W(CW), .PRICE(PRICE), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Output vector: {gnt, done, rej, err, valid, change, amt, busy, fault}
    wire [W-1:0] act = {bus.gnt, bus.done, bus.rej, bus.err, bus.disp_valid,
                        bus.disp_change, bus.disp_chg_amt, bus.busy, bus.fault};

    function automatic logic [W-1:0] pk(input logic [N-1:0] g, d, r, e,
                                        input logic v, c, input logic [CW-1:0] a,
                                        input logic b, f);
        return {g, d, r, e, v, c, a, b, f};
    endfunction

    logic [W-1:0] expv = '0;
    logic [W-1:0] pin_mask = '0;
    logic [W-1:0] pin_val = '0;
    string        pin_name = "";
    int           pin_seq = 0;
    int           pin_seen = 0;
    int           errors = 0;
    int           checks = 0;

    // Reference model state
    int              m_ptr = 0;
    logic            m_chg = 1'b0;
    logic [CW-1:0]   m_amt = '0;

    // Compare process: every cycle against the model, plus literal pins.
    always @(negedge clk) begin
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, expv);
        end
        if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            checks++;
            if ((act & pin_mask) !== pin_val) begin
                errors++;
                $display("FAIL %s t=%0t actual=%h required=%h", pin_name, $time, act & pin_mask, pin_val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [W-1:0] v);
        expv = v;
    endtask

    task automatic pin(input string nm, input logic [W-1:0] m, input logic [W-1:0] v);
        pin_name = nm;
        pin_mask = m;
        pin_val  = v;
        pin_seq++;
    endtask

    task automatic drive_rand(input bit scr);
        if (scr) begin
            bus.req    = N'($urandom);
            bus.credit = (N*CW)'($urandom);
        end
        bus.disp_ready = 1'($urandom);
        bus.disp_done  = 1'($urandom);
        bus.fault_clr  = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_rand(0);
            bus.req = '0;
            tick();
            set_exp(pk('0, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b0, 1'b0));
        end
    endtask

    // One transaction from the arbitration edge to the return to idle.
    // rd: cycles disp_ready is held low; dd: WAIT_DONE cycle of disp_done (-1 never);
    // rst_t: WAIT_DONE cycle at which reset is applied (-1 never).
    // pg/pamt/po: literal grant, change amount and outcome (0 done, 1 rej, 2 err).
    task automatic txn(input logic [N-1:0] r, input logic [N*CW-1:0] cr,
                       input int rd, input int dd, input int fhold, input bit scr,
                       input logic [N-1:0] pg, input int pamt, input int po, input int rst_t);
        int w;
        logic [N-1:0] g;
        logic [CW-1:0] c;
        drive_rand(0);
        bus.req    = r;
        bus.credit = cr;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        g = N'(1) << w;
        c = cr[w*CW +: CW];
        m_ptr = (w + 1) % N;
        tick();
        set_exp(pk(g, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b1, 1'b0));
        if (pg != '0) pin("grant", pk('1, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0),
                                  pk(pg, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
        drive_rand(scr);
        tick();
        if (int'(c) < PRICE) begin
            set_exp(pk(g, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b1, 1'b0));
            drive_rand(scr);
            tick();
            m_chg = 1'b0;
            m_amt = '0;
            set_exp(pk('0, '0, g, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
            if (pg != '0 && po == 1) pin("rej_pulse", pk('1, '1, '1, '1, 1'b1, 1'b0, '0, 1'b0, 1'b0),
                                                      pk('0, '0, pg, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
        end else begin
            m_chg = (int'(c) > PRICE);
            m_amt = c - CW'(PRICE);
            set_exp(pk(g, '0, '0, '0, 1'b1, m_chg, m_amt, 1'b1, 1'b0));
            if (pamt >= 0) pin("change", pk('0, '0, '0, '0, 1'b1, 1'b1, '1, 1'b0, 1'b0),
                                         pk('0, '0, '0, '0, 1'b1, (pamt > 0), CW'(pamt), 1'b0, 1'b0));
            for (int i = 0; i < rd; i++) begin
                drive_rand(scr);
                bus.disp_ready = 1'b0;
                tick();
                set_exp(pk(g, '0, '0, '0, 1'b1, m_chg, m_amt, 1'b1, 1'b0));
            end
            drive_rand(scr);
            bus.disp_ready = 1'b1;
            tick();
            set_exp(pk(g, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b1, 1'b0));
            for (int t = 0; t < TO; t++) begin
                if (t == rst_t) begin
                    rst_n = 1'b0;
                    m_ptr = 0;
                    m_chg = 1'b0;
                    m_amt = '0;
                    set_exp('0);
                    tick();
                    pin("reset_zero", '1, '0);
                    tick();
                    bus.req = '0;
                    rst_n = 1'b1;
                    return;
                end
                drive_rand(scr);
                bus.disp_done = (t == dd);
                tick();
                if (t == dd) begin
                    set_exp(pk(g, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b1, 1'b0));
                    drive_rand(scr);
                    tick();
                    m_chg = 1'b0;
                    m_amt = '0;
                    set_exp(pk('0, g, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
                    if (pg != '0 && po == 0) pin("done_pulse", pk('1, '1, '1, '1, 1'b1, 1'b0, '0, 1'b0, 1'b0),
                                                               pk('0, pg, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0));
                    break;
                end
                if (t == TO - 1) begin
                    set_exp(pk('0, '0, '0, g, 1'b0, m_chg, m_amt, 1'b1, 1'b1));
                    if (pg != '0 && po == 2) pin("err_fault", pk('1, '1, '1, '1, 1'b0, 1'b0, '0, 1'b0, 1'b1),
                                                              pk('0, '0, '0, pg, 1'b0, 1'b0, '0, 1'b0, 1'b1));
                    for (int i = 0; i < fhold; i++) begin
                        drive_rand(1);
                        bus.fault_clr = 1'b0;
                        tick();
                        set_exp(pk('0, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b1, 1'b1));
                    end
                    drive_rand(1);
                    bus.fault_clr = 1'b1;
                    tick();
                    set_exp(pk('0, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b0, 1'b0));
                    bus.fault_clr = 1'b0;
                    break;
                end
                set_exp(pk(g, '0, '0, '0, 1'b0, m_chg, m_amt, 1'b1, 1'b0));
            end
        end
        bus.req = '0;
    endtask

    initial begin
        logic [N-1:0] rr [5];
        logic [N-1:0] rq;
        int           dd;
        rr[0] = 4'b0001; rr[1] = 4'b0010; rr[2] = 4'b0100; rr[3] = 4'b1000; rr[4] = 4'b0001;
        bus.req = '0;
        bus.credit = '0;
        bus.disp_ready = 1'b0;
        bus.disp_done = 1'b0;
        bus.fault_clr = 1'b0;
        tick();
        set_exp('0);
        tick();
        pin("reset_state", '1, '0);
        rst_n = 1'b1;

        // Round robin with all requesters held and equal credit
        for (int i = 0; i < 5; i++)
            txn(4'b1111, {4{4'd2}}, 0, 0, 0, 0, rr[i], 0, 0, -1);
        idle(2);
        // Exact price, no change
        txn(4'b0001, 16'h0002, 0, 2, 0, 1, 4'b0001, 0, 0, -1);
        // Overpaid by 3
        txn(4'b0100, 16'h0500, 1, 4, 0, 1, 4'b0100, 3, 0, -1);
        // Underpaid -> reject
        txn(4'b0010, 16'h0010, 0, 0, 0, 1, 4'b0010, -1, 1, -1);
        // disp_done on the final watchdog cycle wins
        txn(4'b0001, 16'h0003, 0, TO - 1, 0, 1, 4'b0001, 1, 0, -1);
        // Slow ready then watchdog fault, then recovery
        txn(4'b0010, 16'h0030, 5, -1, 4, 1, 4'b0010, 1, 2, -1);
        txn(4'b0100, 16'h0200, 0, 1, 0, 1, 4'b0100, 0, 0, -1);
        // Reset mid-WAIT_DONE, then pointer restarts at 0
        txn(4'b0010, 16'h0020, 0, -1, 0, 1, 4'b0010, 0, 0, 3);
        txn(4'b1000, 16'h2000, 0, 0, 0, 1, 4'b1000, 0, 0, -1);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            rq = N'($urandom_range(1, (1 << N) - 1));
            dd = $urandom_range(0, 19);
            if (dd >= TO) dd = -1;
            txn(rq, (N*CW)'($urandom), $urandom_range(0, 3), dd, $urandom_range(0, 3),
                1'($urandom), '0, -1, 0, -1);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vend_scheduler.md
Name: vend_scheduler

Overview:
- Round-robin scheduler that shares one product/change dispenser among N coin front-ends.
- Each front-end raises a request with the credit it has collected.
- The scheduler grants one requester at a time and checks the credit against PRICE.
- It then issues a dispense command (with change when overpaid), waits for completion under a watchdog, and returns done, reject or error to the granted requester.

Parameters:
- N, 4, number of coin front-ends (requesters).
- CRED_W, 4, width of each credit value in coin units.
- PRICE, 2, product price in coin units (must be < 2^CRED_W).
- TIMEOUT, 16, max cycles in WAIT_DONE before fault (>= 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester transaction request, level.
- credit  in  N*CRED_W  per-requester credit; slice i = credit[i*CRED_W +: CRED_W].
- gnt  out  N  one-hot grant, held for the whole transaction.
- done  out  N  one-cycle pulse: dispense completed for requester i.
- rej  out  N  one-cycle pulse: credit below PRICE, nothing dispensed.
- err  out  N  one-cycle pulse: dispenser timed out.
- disp_valid  out  1  dispense command valid.
- disp_ready  in  1  dispenser accepts command.
- disp_change  out  1  change is to be returned with the product.
- disp_chg_amt  out  CRED_W  change amount = credit - PRICE.
- disp_done  in  1  dispenser finished, single-cycle pulse.
- busy  out  1  high in any state except IDLE.
- fault  out  1  sticky watchdog fault.
- fault_clr  in  1  clears fault, returns to IDLE.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All outputs go to 0.
  - State = IDLE, round-robin pointer = 0, latched index/credit/timer = 0.
  - Reset mid-transaction abandons the transaction; no done/rej/err pulse is produced.
- All outputs are registered.
- States: IDLE, CHECK, ISSUE, WAIT_DONE, RESP, FAULT.
- IDLE, when req != 0:
  - Pick the first set bit searching from ptr upward, modulo N.
  - Latch index and credit slice; set gnt one-hot; ptr <= index+1 mod N; go to CHECK.
- CHECK (1 cycle):
  - credit < PRICE: go to RESP with a reject outcome.
  - Otherwise: disp_valid <= 1, disp_change <= (credit > PRICE), disp_chg_amt <= credit - PRICE (0 when equal); go to ISSUE.
- ISSUE:
  - disp_valid, disp_change and disp_chg_amt are held stable until disp_ready is sampled high.
  - On that edge: disp_valid <= 0, timer <= 0, go to WAIT_DONE.
  - No timeout applies in ISSUE.
- WAIT_DONE:
  - Timer increments each cycle.
  - disp_done high: go to RESP with a done outcome.
  - Timer == TIMEOUT-1 with no disp_done: err[index] pulse, gnt <= 0, fault <= 1, go to FAULT.
  - disp_done in the same cycle as the timeout: done wins.
- RESP:
  - Exactly one of done/rej[index] pulses for one cycle.
  - gnt <= 0, disp_change <= 0, disp_chg_amt <= 0; go to IDLE.
- FAULT:
  - No grants; req ignored; fault held at 1.
  - fault_clr high: fault <= 0, go to IDLE.
- Latency:
  - req sampled at edge k gives gnt after edge k.
  - disp_valid or the transition to RESP follows after edge k+1.
  - rej pulse after edge k+2.
  - done pulse 2 edges after disp_done is sampled in WAIT_DONE.
  - Next grant no earlier than one cycle after the RESP pulse (IDLE re-arbitrates).
- Ignored inputs:
  - req and credit changes after the grant are ignored; the transaction completes on the latched credit.
  - disp_done outside WAIT_DONE is ignored.
  - disp_ready outside ISSUE is ignored.
  - fault_clr outside FAULT is ignored.
- Arithmetic: the subtraction is unsigned CRED_W bits and is only evaluated when credit >= PRICE; no wrap.
- N=1: ptr is always 0 and the single requester is served repeatedly.

Test Plan:
- req=0001, credit0=2, disp_ready=1, disp_done 3 cycles after issue -> gnt=0001; disp_valid for one cycle with disp_change=0, disp_chg_amt=0; done=0001 pulse; gnt cleared; busy=0 afterwards.
- req=0100, credit2=5 -> gnt=0100, disp_valid with disp_change=1, disp_chg_amt=3; done[2] pulse after disp_done.
- req=0010, credit1=1 -> gnt=0010 then rej=0010 one-cycle pulse; disp_valid never asserted.
- req=1111 held, all credits=2, disp_ready/disp_done prompt -> grant order 0001, 0010, 0100, 1000, 0001; each gets one done pulse.
- disp_ready low 5 cycles then high, disp_done never -> disp_valid/disp_change/disp_chg_amt stable for those 5 cycles; after 16 cycles in WAIT_DONE err pulse on granted bit, fault=1; req ignored; fault_clr pulse -> fault=0, next req granted.
- rst_n low during WAIT_DONE -> gnt, busy, disp_* and fault all 0 immediately; no pulses; after release req=1000 is granted (ptr reset to 0, search finds bit 3).
